// File: rtl/jt900h_rep_ctrl.sv
// rtl/jt900h_rep_ctrl.sv - Block transfer / compare sequencer for LDI, LDIR, CPI and CPIR
module jt900h_rep_ctrl #(
   parameter int AW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [2:0]    w,
   input  logic [15:0]   bc_in,
   input  logic [31:0]   xde_in,
   input  logic [31:0]   xhl_in,
   input  logic [15:0]   acc_in,
   input  logic          irq,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_dout,
   input  logic [15:0]   mem_din,
   input  logic          mem_ack,
   output logic [5:0]    alu_sel,
   output logic [2:0]    alu_w,
   output logic [31:0]   alu_op0,
   output logic [31:0]   alu_op1,
   output logic          alu_flag_we,
   input  logic [7:0]    alu_flags,
   output logic          busy,
   output logic          done,
   output logic          rep_pend,
   output logic          bc_nz,
   output logic [15:0]   bc_out,
   output logic [31:0]   xde_out,
   output logic [31:0]   xhl_out
);

   localparam logic [5:0] ALU_SUB = 6'h02;
   localparam logic [1:0] OP_CPIR = 2'd3;
   localparam logic [2:0] W_WORD  = 3'b010;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      CMP,
      CHK,
      NEXT
   } state_t;

   state_t        st, st_nx;
   logic [15:0]   bc;
   logic [31:0]   xde;
   logic [31:0]   xhl;
   logic [15:0]   acc;
   logic [15:0]   data;
   logic [1:0]    op_l;
   logic [2:0]    w_l;
   logic          match;

   logic          is_cp;
   logic          is_rep;
   logic          is_word;
   logic [15:0]   bc_dec;
   logic [31:0]   step;
   logic          term;
   logic          unused_flags;

   assign is_cp   = op_l[1];
   assign is_rep  = op_l[0];
   assign is_word = (w_l == W_WORD);
   assign bc_dec  = bc - 16'd1;
   assign step    = is_word ? 32'd2 : 32'd1;
   // bc_in=0 naturally runs 65536 times because the zero test uses the decremented value
   assign term    = !is_rep || (bc_dec == 16'd0) || ((op_l == OP_CPIR) && match);

   assign unused_flags = ^{alu_flags[7], alu_flags[5:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st <= IDLE;
      end else if (cen) begin
         st <= st_nx;
      end
   end

   always_comb begin
      st_nx       = st;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      alu_sel     = 6'd0;
      alu_w       = 3'd0;
      alu_op0     = 32'd0;
      alu_op1     = 32'd0;
      alu_flag_we = 1'b0;
      case (st)
         IDLE: begin
            if (start) st_nx = RD;
         end
         RD: begin
            mem_req  = 1'b1;
            mem_addr = xhl[AW-1:0];
            if (mem_ack) st_nx = is_cp ? CMP : WR;
         end
         WR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = xde[AW-1:0];
            if (mem_ack) st_nx = NEXT;
         end
         CMP: begin
            alu_sel     = ALU_SUB;
            alu_w       = w_l;
            alu_op0     = {16'd0, acc};
            alu_op1     = {16'd0, data};
            alu_flag_we = 1'b1;
            st_nx       = CHK;
         end
         CHK: begin
            st_nx = NEXT;
         end
         NEXT: begin
            st_nx = (term || irq) ? IDLE : RD;
         end
         default: begin
            st_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bc       <= 16'd0;
         xde      <= 32'd0;
         xhl      <= 32'd0;
         acc      <= 16'd0;
         data     <= 16'd0;
         op_l     <= 2'd0;
         w_l      <= 3'd0;
         match    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rep_pend <= 1'b0;
      end else if (cen) begin
         done <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  bc       <= bc_in;
                  xde      <= xde_in;
                  xhl      <= xhl_in;
                  acc      <= acc_in;
                  op_l     <= op;
                  w_l      <= w;
                  match    <= 1'b0;
                  busy     <= 1'b1;
                  rep_pend <= 1'b0;
               end
            end
            RD: begin
               if (mem_ack) data <= is_word ? mem_din : {8'd0, mem_din[7:0]};
            end
            CHK: begin
               match <= alu_flags[6];
            end
            NEXT: begin
               bc  <= bc_dec;
               xhl <= xhl + step;
               if (!is_cp) xde <= xde + step;
               // An interrupt only stops a repeat that still has work left; rep_pend flags re-issue
               if (term || irq) begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  rep_pend <= !term;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_dout = data;
   assign bc_nz    = (bc != 16'd0);
   assign bc_out   = bc;
   assign xde_out  = xde;
   assign xhl_out  = xhl;

endmodule

// File: tb/tb_jt900h_rep_ctrl.sv
// tb/tb_jt900h_rep_ctrl.sv - Directed self-checking bench for jt900h_rep_ctrl
module tb_jt900h_rep_ctrl;

   localparam int AW = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cen = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    op = 2'd0;
   logic [2:0]    w = 3'd1;
   logic [15:0]   bc_in = 16'd0;
   logic [31:0]   xde_in = 32'd0;
   logic [31:0]   xhl_in = 32'd0;
   logic [15:0]   acc_in = 16'd0;
   logic          irq = 1'b0;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_dout;
   logic [15:0]   mem_din;
   logic          mem_ack;
   logic [5:0]    alu_sel;
   logic [2:0]    alu_w;
   logic [31:0]   alu_op0;
   logic [31:0]   alu_op1;
   logic          alu_flag_we;
   logic [7:0]    alu_flags = 8'd0;
   logic          busy, done, rep_pend, bc_nz;
   logic [15:0]   bc_out;
   logic [31:0]   xde_out, xhl_out;

   jt900h_rep_ctrl #(.AW(AW)) dut (
      .clk(clk), .rst(rst), .cen(cen), .start(start), .op(op), .w(w),
      .bc_in(bc_in), .xde_in(xde_in), .xhl_in(xhl_in), .acc_in(acc_in), .irq(irq),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_ack(mem_ack),
      .alu_sel(alu_sel), .alu_w(alu_w), .alu_op0(alu_op0), .alu_op1(alu_op1),
      .alu_flag_we(alu_flag_we), .alu_flags(alu_flags),
      .busy(busy), .done(done), .rep_pend(rep_pend), .bc_nz(bc_nz),
      .bc_out(bc_out), .xde_out(xde_out), .xhl_out(xhl_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic cen_tog = 1'b0;
   always @(negedge clk) cen = cen_tog ? ~cen : 1'b1;

   // memory model: read-only image plus write log
   logic [15:0] rom [0:4095];
   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          rcnt = 0, wcnt = 0;
   logic [31:0] rlog_addr [0:63];
   logic [31:0] wlog_addr [0:63];
   logic [15:0] wlog_data [0:63];

   assign mem_din = rom[mem_addr[11:0]];
   assign mem_ack = mem_req && (wait_cnt >= ack_delay);

   always @(posedge clk) begin
      if (!rst || !mem_req || (mem_ack && cen)) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
      if (rst && cen && mem_req && mem_ack) begin
         if (mem_we) begin
            wlog_addr[wcnt % 64] <= 32'(mem_addr);
            wlog_data[wcnt % 64] <= mem_dout;
            wcnt <= wcnt + 1;
         end else begin
            rlog_addr[rcnt % 64] <= 32'(mem_addr);
            rcnt <= rcnt + 1;
         end
      end
   end

   // ALU model latching Z on flag writes
   int          alu_cnt = 0;
   logic [31:0] last_op0 = 32'd0, last_op1 = 32'd0;
   logic [5:0]  last_sel = 6'd0;
   logic [2:0]  last_w = 3'd0;
   always @(posedge clk) begin
      if (!rst) alu_flags <= 8'd0;
      else if (cen && alu_flag_we) begin
         alu_flags[6] <= (alu_w == 3'b001) ? (alu_op0[7:0] == alu_op1[7:0])
                                           : (alu_op0[15:0] == alu_op1[15:0]);
         alu_cnt  <= alu_cnt + 1;
         last_op0 <= alu_op0;
         last_op1 <= alu_op1;
         last_sel <= alu_sel;
         last_w   <= alu_w;
      end
   end

   int done_cnt = 0;
   always @(posedge clk) if (rst && cen && done) done_cnt <= done_cnt + 1;

   // request must hold address/direction until accepted
   int          viol = 0;
   logic        prev_pend = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic        prev_we = 1'b0;
   always @(posedge clk) begin
      if (!rst) prev_pend <= 1'b0;
      else begin
         if (prev_pend && (!mem_req || mem_addr != prev_addr || mem_we != prev_we)) viol <= viol + 1;
         prev_pend <= mem_req && !(mem_ack && cen);
         prev_addr <= mem_addr;
         prev_we   <= mem_we;
      end
   end

   task automatic issue(input logic [1:0] o, input logic [2:0] ww, input logic [15:0] bc,
                        input logic [31:0] hl, input logic [31:0] de, input logic [15:0] a);
      op = o; w = ww; bc_in = bc; xhl_in = hl; xde_in = de; acc_in = a;
      do begin
         @(negedge clk);
         #1;
      end while (!cen);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int n = 0; n < 3000; n++) begin
         if (done) break;
         @(negedge clk);
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
   endtask

   task automatic wait_quiet();
      for (int n = 0; n < 100; n++) begin
         if (!done) break;
         @(negedge clk);
      end
   endtask

   task automatic ldir_byte_run(input string tag, input logic [31:0] src, input logic [31:0] dst);
      int r0, w0, d0;
      r0 = rcnt; w0 = wcnt; d0 = done_cnt;
      issue(2'd1, 3'b001, 16'd3, src, dst, 16'd0);
      wait_done(tag);
      check({tag, "_bc"}, 32'(bc_out), 32'd0);
      check({tag, "_xhl"}, xhl_out, src + 32'd3);
      check({tag, "_xde"}, xde_out, dst + 32'd3);
      check({tag, "_bc_nz"}, 32'(bc_nz), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_rep_pend"}, 32'(rep_pend), 32'd0);
      check({tag, "_reads"}, 32'(rcnt - r0), 32'd3);
      check({tag, "_writes"}, 32'(wcnt - w0), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check({tag, "_raddr"}, rlog_addr[(r0 + i) % 64], src + 32'(i));
         check({tag, "_waddr"}, wlog_addr[(w0 + i) % 64], dst + 32'(i));
         check({tag, "_wdata"}, 32'(wlog_data[(w0 + i) % 64]), {24'd0, rom[src[11:0] + 12'(i)][7:0]});
      end
      wait_quiet();
      check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      int r0, w0, a0, d0, n;
      for (int i = 0; i < 4096; i++) rom[i] = 16'(i * 7 + 16'h5A00);
      rom[12'h100] = 16'h11AA; rom[12'h101] = 16'h22BB; rom[12'h102] = 16'h33CC;
      rom[12'h300] = 16'h5678; rom[12'h302] = 16'h1234;
      rom[12'h500] = 16'h9942;
      rom[12'h600] = 16'hA1B2; rom[12'h601] = 16'hC3D4; rom[12'h602] = 16'hE5F6;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rep_pend", 32'(rep_pend), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_alu_we", 32'(alu_flag_we), 32'd0);
      check("rst_alu_w", 32'(alu_w), 32'd0);
      check("rst_bc", 32'(bc_out), 32'd0);
      check("rst_xhl", xhl_out, 32'd0);
      check("rst_xde", xde_out, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      ldir_byte_run("ldir", 32'h100, 32'h200);

      r0 = rcnt; w0 = wcnt; a0 = alu_cnt;
      issue(2'd3, 3'b010, 16'd5, 32'h300, 32'h400, 16'h1234);
      wait_done("cpir");
      check("cpir_bc", 32'(bc_out), 32'd3);
      check("cpir_xhl", xhl_out, 32'h304);
      check("cpir_xde", xde_out, 32'h400);
      check("cpir_bc_nz", 32'(bc_nz), 32'd1);
      check("cpir_reads", 32'(rcnt - r0), 32'd2);
      check("cpir_writes", 32'(wcnt - w0), 32'd0);
      check("cpir_alu_pulses", 32'(alu_cnt - a0), 32'd2);
      check("cpir_raddr1", rlog_addr[(r0 + 1) % 64], 32'h302);
      check("cpir_alu_sel", 32'(last_sel), 32'h02);
      check("cpir_alu_w", 32'(last_w), 32'd2);
      check("cpir_alu_op0", last_op0, 32'h1234);
      check("cpir_alu_op1", last_op1, 32'h1234);
      wait_quiet();

      w0 = wcnt; d0 = done_cnt;
      issue(2'd1, 3'b001, 16'd4, 32'h500, 32'h580, 16'd0);
      irq = 1'b1;
      wait_done("irq");
      check("irq_rep_pend", 32'(rep_pend), 32'd1);
      check("irq_bc", 32'(bc_out), 32'd3);
      check("irq_xhl", xhl_out, 32'h501);
      check("irq_writes", 32'(wcnt - w0), 32'd1);
      check("irq_wdata", 32'(wlog_data[w0 % 64]), 32'h42);
      irq = 1'b0;
      wait_quiet();
      check("irq_done_pulses", 32'(done_cnt - d0), 32'd1);

      r0 = rcnt;
      issue(2'd0, 3'b001, 16'd0, 32'h510, 32'h590, 16'd0);
      wait_done("ldi0");
      check("ldi0_bc", 32'(bc_out), 32'hFFFF);
      check("ldi0_bc_nz", 32'(bc_nz), 32'd1);
      check("ldi0_rep_pend", 32'(rep_pend), 32'd0);
      check("ldi0_xde", xde_out, 32'h591);
      check("ldi0_reads", 32'(rcnt - r0), 32'd1);
      wait_quiet();

      w0 = wcnt; d0 = done_cnt;
      issue(2'd1, 3'b001, 16'd0, 32'h800, 32'h900, 16'd0);
      for (n = 0; n < 200 && wcnt != w0 + 3; n++) @(negedge clk);
      check("ldir0_three_writes", 32'(wcnt - w0), 32'd3);
      @(negedge clk);
      check("ldir0_bc_wrap", 32'(bc_out), 32'hFFFD);
      check("ldir0_busy", 32'(busy), 32'd1);
      check("ldir0_no_done", 32'(done_cnt - d0), 32'd0);
      for (n = 0; n < 20 && !mem_we; n++) @(negedge clk);
      check("rstwr_in_wr", 32'(mem_we), 32'd1);
      rst = 1'b0;
      #1;
      check("rstwr_mem_req", 32'(mem_req), 32'd0);
      check("rstwr_busy", 32'(busy), 32'd0);
      check("rstwr_bc", 32'(bc_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_req || alu_flag_we) n++;
      end
      check("rstwr_quiet", 32'(n), 32'd0);

      cen_tog = 1'b1;
      ack_delay = 3;
      ldir_byte_run("slow", 32'h600, 32'h700);
      cen_tog = 1'b0;
      ack_delay = 0;
      check("addr_stable_viol", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jt900h_rep_ctrl.md
JT900H_REP_CTRL -- requirements
Module: jt900h_rep_ctrl

Interface
REQ-001 SHALL have parameter AW, default 24, meaning memory address width.
REQ-002 SHALL have port clk, input, 1, system clock, rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port cen, input, 1, clock enable; all state advances only when cen=1.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a block instruction.
REQ-006 SHALL have port op, input, 2, 0=LDI 1=LDIR 2=CPI 3=CPIR.
REQ-007 SHALL have port w, input, 3, width in ALU encoding: 3'b001=byte, 3'b010=word.
REQ-008 SHALL have ports bc_in/xde_in/xhl_in/acc_in, inputs, 16/32/32/16: counter, destination, source and compare operands.
REQ-009 SHALL have port irq, input, 1, interrupt pending.
REQ-010 SHALL have ports mem_req/mem_we/mem_addr/mem_dout, outputs, 1/1/AW/16, and mem_din/mem_ack, inputs, 16/1.
REQ-011 SHALL have ports alu_sel/alu_w/alu_op0/alu_op1/alu_flag_we, outputs, 6/3/32/32/1, and alu_flags, input, 8 (bit 6 = Z).
REQ-012 SHALL have ports busy, done, rep_pend, bc_nz, outputs, 1 each; bc_out/xde_out/xhl_out, outputs, 16/32/32.

Function
REQ-013 SHALL use states IDLE, RD, WR, CMP, CHK, NEXT.
REQ-014 SHALL, in IDLE with start=1 and cen=1, latch all operands, set busy=1, and go to RD; start SHALL be ignored while busy=1.
REQ-015 SHALL, in RD, assert mem_req=1, mem_we=0, mem_addr=xhl[AW-1:0], and hold them until mem_ack=1 is sampled with cen=1.
REQ-016 SHALL, on RD ack, latch mem_din (byte mode: low 8 bits, upper bits zero), then go to WR for LD ops or CMP for CP ops.
REQ-017 SHALL, in WR, assert mem_req=1, mem_we=1, mem_addr=xde[AW-1:0], mem_dout=latched data, holding until ack, then go to NEXT.
REQ-018 SHALL, in CMP, drive for exactly one cen cycle alu_sel=ALU_SUB, alu_w=w, alu_op0=acc, alu_op1=data, alu_flag_we=1, then go to CHK; in all other states alu_w=0 and alu_flag_we=0.
REQ-019 SHALL, in CHK, sample match=alu_flags[6], then go to NEXT.
REQ-020 SHALL, in NEXT, decrement bc by 1 mod 2^16, add step to xhl (LD and CP) and xde (LD only), mod 2^32, where step=1 byte, 2 word.
REQ-021 SHALL, in NEXT, terminate when op is LDI/CPI, or new bc==0, or (CPIR and match=1); otherwise go to RD.
REQ-022 SHALL, in NEXT when not terminating and irq=1, stop with rep_pend=1 so the instruction is re-issued after the interrupt.
REQ-023 SHALL, on termination, pulse done=1 for one cen cycle, clear busy in the same cycle, and return to IDLE.
REQ-024 SHALL drive bc_nz=(bc!=0) and bc_out/xde_out/xhl_out as the live registers, valid when done=1.
REQ-025 SHALL treat bc_in=0 as 65536 iterations (decrement wraps to 0xFFFF before the test).
REQ-026 SHALL hold all state when cen=0, including a pending mem_ack, which is only sampled with cen=1.
REQ-027 SHALL accept mem_ack in the first cycle mem_req is asserted (zero-wait memory).

Reset
REQ-028 SHALL, on rst=0, immediately force IDLE, with busy=0, done=0, rep_pend=0, mem_req=0, mem_we=0, alu_flag_we=0, alu_w=0, match=0, and all counters and pointers 0.
REQ-029 SHALL, on reset mid-operation, abandon the transfer with no further memory or ALU request after release.

Verification
REQ-030 LDIR byte, bc=3, xhl=0x100, xde=0x200, zero-wait memory -> 3 reads and 3 writes (0x100->0x200, 0x101->0x201, 0x102->0x202); done with bc_out=0, xhl_out=0x103, xde_out=0x203, bc_nz=0.
REQ-031 CPIR word, acc=0x1234, bc=5, data at the second read=0x1234 -> 2 iterations, 2 ALU_SUB pulses; done with bc_out=3, xhl_out=xhl_in+4, bc_nz=1.
REQ-032 LDIR bc=4, irq raised during the first iteration -> stop after 1 iteration with rep_pend=1, bc_out=3, done pulse.
REQ-033 LDI bc=0 -> 1 iteration, bc_out=0xFFFF, bc_nz=1; LDIR bc=0 -> bc wraps and no termination before 65536 iterations (check 3 iterations, then reset).
REQ-034 mem_ack delayed 3 cycles, cen toggling 1/0 -> mem_req/mem_addr stable until the acked cycle; results identical to the no-wait run.
REQ-035 rst=0 during WR -> mem_req=0 asynchronously; after release busy=0 and start is accepted again.
